conv1d_mac_sequencer: RTL
=========================

// Module: conv1d_mac_sequencer
// PURPOSE
//  Sequences the 1-D convolution MAC datapath for the ECG classifier.
//  For each output position, reads KERNEL_SIZE filter taps and activations from synchronous-read buffers.
//  Drives the MAC tap counter, captures each accumulated result and streams it out on a valid/ready port.
//  Sits between the layer controller (start/cfg) and the ALU/MAC, and feeds the next-layer write path.
// PARAMETERS
//  DATA_WIDTH   16   operand/result width (signed Q-format, same as MAC)
//  ADDR_WIDTH   8    buffer address width
//  KERNEL_SIZE  5    taps per output; the tap counter runs 0..KERNEL_SIZE-1
//  IA_LEN       187  activation samples per channel (one ECG beat)
//  STRIDE       1    activation address step between output positions
// PORTS
//  clk              in   1           clock, all logic on rising edge
//  rst              in   1           synchronous reset, active-high
//  start            in   1           1-cycle pulse; begins a layer pass when IDLE
//  cfg_num_out      in   ADDR_WIDTH  output positions requested (sampled on start)
//  cfg_filt_base    in   ADDR_WIDTH  filter buffer base address (sampled on start)
//  busy             out  1           high from accepted start until done
//  done             out  1           1-cycle pulse after the final output handshake
//  filt_addr        out  ADDR_WIDTH  filter buffer read address (1-cycle read latency)
//  ia_addr          out  ADDR_WIDTH  activation buffer read address (1-cycle read latency)
//  rd_en            out  1           read strobe to both buffers
//  mac_ctrl_counter out  3           tap index to MAC, aligned with returned buffer data
//  mac_data_in      in   DATA_WIDTH  accumulated MAC result
//  mac_valid_in     in   1           MAC result valid (final tap accumulated)
//  out_data         out  DATA_WIDTH  conv result for current position
//  out_valid        out  1           out_data valid
//  out_ready        in   1           downstream accepts when valid&&ready
//  out_last         out  1           qualifies final position of the pass
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters cleared. Reset mid-pass aborts it; no done is issued.
//  FSM states:
//   IDLE : wait for start. start while not IDLE is ignored.
//   ISSUE: KERNEL_SIZE consecutive cycles, rd_en=1, tap t=0..K-1.
//          filt_addr = base+t; ia_addr = pos*STRIDE+t.
//   DRAIN: wait for mac_valid_in; capture mac_data_in into the output register.
//   OUT  : out_valid=1, held stable until out_ready. Then pos++.
//          If pos==num_out, go to IDLE and pulse done. Otherwise go to ISSUE.
//  mac_ctrl_counter = tap index delayed 1 cycle (matches read latency). It is 0 outside an active tap cycle.
//  Latency: start -> first rd_en = 1 cycle. Last tap issue -> capture occurs when MAC flags valid.
//  Back-pressure: a single output register; issue stalls in OUT. No tap is issued while out_valid&&!out_ready.
//  num_out clamp: effective count = min(cfg_num_out, (IA_LEN-KERNEL_SIZE)/STRIDE+1).
//   ia_addr never exceeds IA_LEN-1.
//  cfg_num_out==0: no reads and no out_valid. done pulses 1 cycle after start; busy is high for exactly that cycle.
//  out_last = out_valid && (pos==num_out-1).
//  Address arithmetic is unsigned, ADDR_WIDTH bits; the filter base+tap wraps modulo 2^ADDR_WIDTH.
// CONFIGURATION
//  RELU_EN defined : out_data = (captured<0) ? 0 : captured (signed compare).
//  RELU_EN undefined: out_data = captured result unchanged.
//  Timing and handshake are identical in both builds.
// STRUCTURE
//  Shared package ecg_cnn_pkg holds:
//   - FSM state encoding (IDLE/ISSUE/DRAIN/OUT)
//   - KERNEL_SIZE, IA_LEN defaults
//   - TAP_CNT_W = 3
//  Sub-module conv_addr_gen: pos/tap counters plus filt_addr/ia_addr/rd_en generation.
//  The top level keeps the FSM, the ctrl-counter delay, the output register and the ReLU.
// TESTING
//  1. num_out=3, base=0, filt=1.0, ia=ramp, ready=1.
//     -> 3 outputs, out_last on 3rd, done 1 cycle later; ia_addr seq 0-4,1-5,2-6.
//  2. ready held 0 for 10 cycles on output 1.
//     -> out_data stable, no rd_en during stall; resumes correctly.
//  3. cfg_num_out=0.
//     -> no rd_en, no out_valid, done pulse 1 cycle after start.
//  4. cfg_num_out=255 with IA_LEN=187, K=5.
//     -> exactly 183 outputs; max ia_addr=186.
//  5. rst asserted during ISSUE of position 2.
//     -> all outputs 0 next cycle; new start runs cleanly from pos 0.
//  6. Negative MAC result -8 (RELU_EN on/off).
//     -> out_data 0 / -8; start pulsed while busy is ignored.

Source files
------------

// File: rtl/ecg_cnn_pkg.sv
// Shared ECG CNN definitions: sequencer FSM encoding, layer defaults, tap counter width.
package ecg_cnn_pkg;

  localparam int unsigned KERNEL_SIZE_DEFAULT = 5;
  localparam int unsigned IA_LEN_DEFAULT      = 187;
  localparam int unsigned TAP_CNT_W           = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: position/tap counters and registered buffer read address generation.
// Addresses are kept as running registers so no multiply is needed for pos*STRIDE.
module conv_addr_gen
  import ecg_cnn_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned KERNEL_SIZE = KERNEL_SIZE_DEFAULT,
  parameter int unsigned STRIDE      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_filt_base,
  input  logic                  i_issue_begin,
  input  logic                  i_pos_adv,
  output logic                  o_rd_en,
  output logic                  o_last_tap_c,
  output logic [TAP_CNT_W-1:0]  o_tap,
  output logic [ADDR_WIDTH-1:0] o_pos,
  output logic [ADDR_WIDTH-1:0] o_filt_addr,
  output logic [ADDR_WIDTH-1:0] o_ia_addr
);

  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_pos;
  logic [ADDR_WIDTH-1:0] r_ia_base;
  logic [TAP_CNT_W-1:0]  r_tap;
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_filt_addr;
  logic [ADDR_WIDTH-1:0] r_ia_addr;
  logic [ADDR_WIDTH-1:0] w_base_sel;
  logic [ADDR_WIDTH-1:0] w_ia_base_nxt;

  // Base/row-start values seen by the first tap of the next burst
  always_comb begin
    w_base_sel    = i_load ? i_filt_base : r_base;
    w_ia_base_nxt = r_ia_base;
    if (i_load) begin
      w_ia_base_nxt = '0;
    end else if (i_pos_adv) begin
      w_ia_base_nxt = r_ia_base + ADDR_WIDTH'(STRIDE);
    end
  end

  // Counter and address registers; one burst of KERNEL_SIZE reads per position
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base      <= '0;
      r_pos       <= '0;
      r_ia_base   <= '0;
      r_tap       <= '0;
      r_rd_en     <= 1'b0;
      r_filt_addr <= '0;
      r_ia_addr   <= '0;
    end else begin
      if (i_load) begin
        r_base <= i_filt_base;
        r_pos  <= '0;
      end else if (i_pos_adv) begin
        r_pos <= r_pos + ADDR_WIDTH'(1);
      end
      r_ia_base <= w_ia_base_nxt;
      if (i_issue_begin) begin
        r_rd_en     <= 1'b1;
        r_tap       <= '0;
        r_filt_addr <= w_base_sel;
        r_ia_addr   <= w_ia_base_nxt;
      end else if (r_rd_en) begin
        if (o_last_tap_c) begin
          r_rd_en <= 1'b0;
          r_tap   <= '0;
        end else begin
          r_tap       <= r_tap + TAP_CNT_W'(1);
          r_filt_addr <= r_filt_addr + ADDR_WIDTH'(1);
          r_ia_addr   <= r_ia_addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign o_last_tap_c = r_rd_en && (r_tap == TAP_CNT_W'(KERNEL_SIZE - 1));
  assign o_rd_en      = r_rd_en;
  assign o_tap        = r_tap;
  assign o_pos        = r_pos;
  assign o_filt_addr  = r_filt_addr;
  assign o_ia_addr    = r_ia_addr;

endmodule

// File: rtl/conv1d_mac_sequencer.sv
// conv1d_mac_sequencer: per-position tap issue, MAC result capture and valid/ready output.
// Build macro RELU_EN: when defined, negative captured results are clamped to zero.
module conv1d_mac_sequencer
  import ecg_cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned KERNEL_SIZE = KERNEL_SIZE_DEFAULT,
  parameter int unsigned IA_LEN      = IA_LEN_DEFAULT,
  parameter int unsigned STRIDE      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_num_out,
  input  logic [ADDR_WIDTH-1:0] cfg_filt_base,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] filt_addr,
  output logic [ADDR_WIDTH-1:0] ia_addr,
  output logic                  rd_en,
  output logic [TAP_CNT_W-1:0]  mac_ctrl_counter,
  input  logic [DATA_WIDTH-1:0] mac_data_in,
  input  logic                  mac_valid_in,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int unsigned MAX_OUT = (IA_LEN - KERNEL_SIZE) / STRIDE + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_OUT_A = ADDR_WIDTH'(MAX_OUT);

  seq_state_e            r_state;
  seq_state_e            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_num;
  logic [ADDR_WIDTH-1:0] w_num_clamped;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [DATA_WIDTH-1:0] w_result;
  logic [TAP_CNT_W-1:0]  r_ctrl;
  logic                  w_load;
  logic                  w_issue_begin;
  logic                  w_pos_adv;
  logic                  w_capture;
  logic                  w_done_nxt;
  logic                  w_rd_en;
  logic                  w_last_tap;
  logic [TAP_CNT_W-1:0]  w_tap;
  logic [ADDR_WIDTH-1:0] w_pos;
  logic [ADDR_WIDTH-1:0] w_filt_addr;
  logic [ADDR_WIDTH-1:0] w_ia_addr;

  assign w_num_clamped = (cfg_num_out > MAX_OUT_A) ? MAX_OUT_A : cfg_num_out;

`ifdef RELU_EN
  assign w_result = ($signed(mac_data_in) < 0) ? '0 : mac_data_in;
`else
  assign w_result = mac_data_in;
`endif

  conv_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .KERNEL_SIZE (KERNEL_SIZE),
    .STRIDE      (STRIDE)
  ) u_addr_gen (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_load),
    .i_filt_base   (cfg_filt_base),
    .i_issue_begin (w_issue_begin),
    .i_pos_adv     (w_pos_adv),
    .o_rd_en       (w_rd_en),
    .o_last_tap_c  (w_last_tap),
    .o_tap         (w_tap),
    .o_pos         (w_pos),
    .o_filt_addr   (w_filt_addr),
    .o_ia_addr     (w_ia_addr)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_issue_begin = 1'b0;
    w_pos_adv     = 1'b0;
    w_capture     = 1'b0;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          if (w_num_clamped == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_issue_begin = 1'b1;
            w_state_nxt   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (w_last_tap) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mac_valid_in) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          w_pos_adv = 1'b1;
          if ((w_pos + ADDR_WIDTH'(1)) == r_num) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_issue_begin = 1'b1;
            w_state_nxt   = ST_ISSUE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered status, tap-index delay and the single output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ctrl      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      r_busy <= (w_state_nxt != ST_IDLE) || w_done_nxt;
      r_ctrl <= w_rd_en ? w_tap : '0;
      if (w_load) begin
        r_num <= w_num_clamped;
      end
      if (w_capture) begin
        r_out_data  <= w_result;
        r_out_valid <= 1'b1;
        r_out_last  <= (w_pos == (r_num - ADDR_WIDTH'(1)));
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign rd_en            = w_rd_en;
  assign filt_addr        = w_filt_addr;
  assign ia_addr          = w_ia_addr;
  assign mac_ctrl_counter = r_ctrl;
  assign out_data         = r_out_data;
  assign out_valid        = r_out_valid;
  assign out_last         = r_out_last;

endmodule
